// File: rtl/fb_pkg.sv
// Shared constants and enums for the frame-buffer access arbiter.
// Display geometry defaults plus the FSM and memory-slot encodings.
package fb_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_TOTAL  = 525;

    typedef enum logic [1:0] {
        OFF,
        SYNC,
        SCAN
    } fb_state_e;

    typedef enum logic [1:0] {
        SLOT_NONE,
        SLOT_RD,
        SLOT_WR
    } fb_slot_e;

endpackage

// File: rtl/fb_pix_pipe.sv
// Display-side alignment: carries each pixel strobe and its active flag for three
// cycles so the captured byte lines up with the SRAM read latency.
module fb_pix_pipe #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear_i,
    input  logic              stb_i,
    input  logic              act_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] pix_data_o,
    output logic              pix_valid_o
);

    logic [1:0]        stb_q, stb_d;
    logic [1:0]        act_q, act_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic              pix_valid_q, pix_valid_d;

    always_comb begin
        stb_d       = {stb_q[0], stb_i};
        act_d       = {act_q[0], act_i};
        pix_data_d  = pix_data_q;
        pix_valid_d = pix_valid_q;
        // Stage 2 coincides with mem_rdata for the strobe's read.
        if (stb_q[1]) begin
            pix_valid_d = act_q[1];
            pix_data_d  = act_q[1] ? mem_rdata_i : '0;
        end
        if (clear_i) begin
            stb_d       = '0;
            act_d       = '0;
            pix_data_d  = '0;
            pix_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stb_q       <= '0;
            act_q       <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            stb_q       <= stb_d;
            act_q       <= act_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign pix_data_o  = pix_data_q;
    assign pix_valid_o = pix_valid_q;

endmodule

// File: rtl/fb_access_arbiter.sv
// Shares the single-port frame-buffer SRAM between VGA scan-out reads and a pixel
// writer; display reads take strobe cycles, the writer gets every other cycle.
module fb_access_arbiter #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              enable,
    input  logic              pixel_clk,
    input  logic [9:0]        counter_out_col,
    input  logic [9:0]        counter_out_row,
    input  logic [ADDR_W-1:0] counter_out_addr,
    input  logic              vblank_only,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              frame_start
);

    import fb_pkg::*;

    localparam logic [9:0] HActive = 10'(H_ACTIVE);
    localparam logic [9:0] VActive = 10'(V_ACTIVE);

    fb_state_e         state_q, state_d;
    fb_slot_e          slot;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic              wr_ack_q, wr_ack_d;
    logic              frame_start_q, frame_start_d;
    logic              active, vblank, frame_origin, live;

    assign active       = (counter_out_col < HActive) && (counter_out_row < VActive);
    assign vblank       = (counter_out_row >= VActive);
    assign frame_origin = pixel_clk && (counter_out_col == '0) && (counter_out_row == '0);
    assign live         = enable && (state_q != OFF);

    always_comb begin
        state_d       = state_q;
        slot          = SLOT_NONE;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_we_d      = 1'b0;
        mem_re_d      = 1'b0;
        wr_ack_d      = 1'b0;
        frame_start_d = 1'b0;

        if (!enable) begin
            state_d = OFF;
        end else begin
            unique case (state_q)
                OFF:     state_d = SYNC;
                SYNC:    if (frame_origin) state_d = SCAN;
                SCAN:    state_d = SCAN;
                default: state_d = OFF;
            endcase
        end

        // Reads win the strobe slot; !wr_ack_q stops a second grant while the
        // writer is still holding wr_req during its ack cycle.
        if (live) begin
            frame_start_d = frame_origin;
            if ((state_q == SCAN) && pixel_clk && active) begin
                slot = SLOT_RD;
            end else if (wr_req && !wr_ack_q && (!vblank_only || vblank)) begin
                slot = SLOT_WR;
            end
        end

        unique case (slot)
            SLOT_RD: begin
                mem_re_d   = 1'b1;
                mem_addr_d = counter_out_addr;
            end
            SLOT_WR: begin
                mem_we_d    = 1'b1;
                wr_ack_d    = 1'b1;
                mem_addr_d  = wr_addr;
                mem_wdata_d = wr_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= OFF;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            wr_ack_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_q      <= mem_we_d;
            mem_re_q      <= mem_re_d;
            wr_ack_q      <= wr_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    fb_pix_pipe #(
        .DATA_W (DATA_W)
    ) u_pix_pipe (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear_i     (state_q == OFF),
        .stb_i       (enable && (state_q == SCAN) && pixel_clk),
        .act_i       (active),
        .mem_rdata_i (mem_rdata),
        .pix_data_o  (pix_data),
        .pix_valid_o (pix_valid)
    );

    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;
    assign wr_ack      = wr_ack_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter: inputs change 1 time unit after the rising
// edge and outputs are sampled there, i.e. showing the registered result of the prior cycle.
module tb_fb_access_arbiter;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 20;

    logic              clk = 1'b0;
    logic              n_rst, enable, pixel_clk, vblank_only, wr_req;
    logic [9:0]        col, row;
    logic [ADDR_W-1:0] addr, wr_addr;
    logic [DATA_W-1:0] wr_data, mem_rdata;
    logic              wr_ack, mem_we, mem_re, pix_valid, frame_start;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, pix_data;
    logic [40:0]       outs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign outs = {wr_ack, mem_addr, mem_wdata, mem_we, mem_re, pix_data, pix_valid, frame_start};

    fb_access_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .H_ACTIVE (640),
        .V_ACTIVE (480)
    ) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .enable           (enable),
        .pixel_clk        (pixel_clk),
        .counter_out_col  (col),
        .counter_out_row  (row),
        .counter_out_addr (addr),
        .vblank_only      (vblank_only),
        .wr_req           (wr_req),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_ack           (wr_ack),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_we           (mem_we),
        .mem_re           (mem_re),
        .mem_rdata        (mem_rdata),
        .pix_data         (pix_data),
        .pix_valid        (pix_valid),
        .frame_start      (frame_start)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] lin(input int c, input int r);
        return ADDR_W'(r * 640 + c);
    endfunction

    task automatic drive(input logic stb, input int c, input int r, input logic [ADDR_W-1:0] a);
        pixel_clk = stb;
        col       = 10'(c);
        row       = 10'(r);
        addr      = a;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; enable = 1'b0; vblank_only = 1'b0; wr_req = 1'b0;
        wr_addr = 20'h11111; wr_data = 8'h55; mem_rdata = 8'h00;
        drive(1'b0, 10, 10, lin(10, 10));
        #3;
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        tick();
        n_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_req = i[0];
            drive(i[0], 10 + i, 10, lin(10 + i, 10));
            tick();
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL idle_disabled: cycle %0d got %h want 0", i, outs);
            end
        end
        wr_req = 1'b0;
    endtask

    task automatic test_frame_sync();
        int c;
        int r;
        int pulses;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5 + i, 3, lin(5 + i, 3));
            tick();
            checks++;
            if (mem_re !== 1'b0 || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL sync_no_read: pix %0d got re=%b fs=%b want 0 0", i, mem_re, frame_start);
            end
            drive(1'b0, 5 + i, 3, lin(5 + i, 3));
            tick();
        end
        drive(1'b1, 0, 0, lin(0, 0));
        tick();
        checks++;
        if (frame_start !== 1'b1 || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL sync_lock: got fs=%b re=%b want 1 0", frame_start, mem_re);
        end
        drive(1'b0, 0, 0, lin(0, 0));
        tick();
        checks++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL fs_one_cycle: got %b want 0", frame_start);
        end
        drive(1'b1, 1, 0, lin(1, 0));
        tick();
        checks++;
        if (mem_re !== 1'b1 || mem_addr !== lin(1, 0)) begin
            errors++;
            $display("FAIL first_scan_read: got re=%b addr=%h want 1 %h", mem_re, mem_addr, lin(1, 0));
        end
        drive(1'b0, 1, 0, lin(1, 0));
        tick();
        c = 795; r = 524; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, c, r, lin(c, r));
            tick();
            if (frame_start === 1'b1) pulses++;
            drive(1'b0, c, r, lin(c, r));
            tick();
            if (frame_start === 1'b1) pulses++;
            c++;
            if (c == 800) begin
                c = 0;
                r = (r == 524) ? 0 : r + 1;
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL fs_per_frame: got %0d pulses want 1", pulses);
        end
    endtask

    task automatic test_display_read();
        drive(1'b1, 10, 2, 20'h00A0A);
        tick();
        checks++;
        if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 20'h00A0A) begin
            errors++;
            $display("FAIL rd_issue: got re=%b we=%b addr=%h want 1 0 00a0a", mem_re, mem_we, mem_addr);
        end
        drive(1'b0, 10, 2, 20'h00A0A);
        tick();
        checks++;
        if (mem_re !== 1'b0 || pix_data !== 8'h00 || pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL rd_not_early: got re=%b pix=%h v=%b want 0 00 1", mem_re, pix_data, pix_valid);
        end
        mem_rdata = 8'h5C;
        tick();
        checks++;
        if (pix_data !== 8'h5C || pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL rd_pixel: got pix=%h v=%b want 5c 1", pix_data, pix_valid);
        end
    endtask

    task automatic test_contention();
        int acks;
        int overlap;
        wr_addr = 20'h12345; wr_data = 8'hA7; wr_req = 1'b1;
        drive(1'b1, 20, 10, lin(20, 10));
        tick();
        checks++;
        if (mem_re !== 1'b1 || mem_we !== 1'b0 || wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL cont_read_first: got re=%b we=%b ack=%b want 1 0 0", mem_re, mem_we, wr_ack);
        end
        drive(1'b0, 20, 10, lin(20, 10));
        tick();
        checks++;
        if (mem_we !== 1'b1 || wr_ack !== 1'b1 || mem_re !== 1'b0 ||
            mem_addr !== 20'h12345 || mem_wdata !== 8'hA7) begin
            errors++;
            $display("FAIL cont_grant: got we=%b ack=%b re=%b addr=%h wd=%h want 1 1 0 12345 a7",
                     mem_we, wr_ack, mem_re, mem_addr, mem_wdata);
        end
        drive(1'b1, 21, 10, lin(21, 10));
        tick();
        checks++;
        if (mem_re !== 1'b1 || mem_we !== 1'b0 || wr_ack !== 1'b0 || mem_addr !== lin(21, 10)) begin
            errors++;
            $display("FAIL cont_after_ack: got re=%b we=%b ack=%b addr=%h want 1 0 0 %h",
                     mem_re, mem_we, wr_ack, mem_addr, lin(21, 10));
        end
        wr_req = 1'b0; acks = 0; overlap = 0;
        for (int i = 0; i < 8; i++) begin
            drive(!i[0], 21 + i / 2, 10, lin(21 + i / 2, 10));
            tick();
            if (wr_ack === 1'b1) acks++;
            if (mem_re === 1'b1 && mem_we === 1'b1) overlap++;
        end
        checks++;
        if (acks != 0 || overlap != 0) begin
            errors++;
            $display("FAIL cont_no_dup: got acks=%0d overlap=%0d want 0 0", acks, overlap);
        end
    endtask

    task automatic test_tear_free();
        int acks;
        vblank_only = 1'b1; wr_addr = 20'h0BEEF; wr_data = 8'h3C; wr_req = 1'b1; acks = 0;
        for (int i = 0; i < 6; i++) begin
            drive(!i[0], 100 + i, 100, lin(100 + i, 100));
            tick();
            if (wr_ack === 1'b1) acks++;
        end
        for (int i = 0; i < 6; i++) begin
            drive(!i[0], 700 + i, 479, lin(700 + i, 479));
            tick();
            if (wr_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL tf_withheld: got %0d acks want 0", acks);
        end
        drive(1'b0, 0, 480, lin(0, 480));
        tick();
        checks++;
        if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 20'h0BEEF || mem_wdata !== 8'h3C) begin
            errors++;
            $display("FAIL tf_grant: got ack=%b we=%b addr=%h wd=%h want 1 1 0beef 3c",
                     wr_ack, mem_we, mem_addr, mem_wdata);
        end
        drive(1'b0, 1, 480, lin(1, 480));
        tick();
        checks++;
        if (wr_ack !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL tf_no_dup: got ack=%b we=%b want 0 0", wr_ack, mem_we);
        end
        wr_req = 1'b0; vblank_only = 1'b0;
    endtask

    task automatic test_blank_abort();
        mem_rdata = 8'h33;
        drive(1'b1, 30, 6, lin(30, 6));
        tick();
        drive(1'b0, 30, 6, lin(30, 6));
        tick();
        tick();
        checks++;
        if (pix_data !== 8'h33 || pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL blank_pre: got pix=%h v=%b want 33 1", pix_data, pix_valid);
        end
        drive(1'b1, 700, 6, lin(700, 6));
        tick();
        checks++;
        if (mem_re !== 1'b0) begin
            errors++;
            $display("FAIL blank_no_read: got re=%b want 0", mem_re);
        end
        drive(1'b0, 700, 6, lin(700, 6));
        tick();
        tick();
        checks++;
        if (pix_data !== 8'h00 || pix_valid !== 1'b0) begin
            errors++;
            $display("FAIL blank_pix: got pix=%h v=%b want 00 0", pix_data, pix_valid);
        end
        wr_addr = 20'h0ABCD; wr_data = 8'h99; wr_req = 1'b1;
        drive(1'b0, 31, 6, lin(31, 6));
        tick();
        checks++;
        if (wr_ack !== 1'b1 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: got ack=%b we=%b want 1 1", wr_ack, mem_we);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL abort_clear: got %h want 0", outs);
        end
        wr_req = 1'b0;
        tick();
        n_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32 + i, 6, lin(32 + i, 6));
            tick();
            checks++;
            if (wr_ack !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
                errors++;
                $display("FAIL abort_after: cycle %0d got ack=%b we=%b re=%b want 0 0 0",
                         i, wr_ack, mem_we, mem_re);
            end
            drive(1'b0, 32 + i, 6, lin(32 + i, 6));
            tick();
        end
    endtask

    initial begin
        n_rst = 1'b0;
        test_reset();
        test_frame_sync();
        test_display_read();
        test_contention();
        test_tear_free();
        test_blank_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
- Sequences and shares the single-port frame-buffer SRAM between two requesters: the VGA scan-out path and a pixel writer (host/image loader).
- Sits beside the timing top and consumes its pixel strobe, column/row counts and linear pixel address.
- Issues one display read per active pixel. Grants writer requests on all remaining memory cycles, or only during vertical blanking when tear-free mode is selected.
- Delivers the fetched pixel byte, blanked to zero outside the active area.

Parameters:
- DATA_W, 8, pixel/memory data width
- ADDR_W, 20, memory address width
- H_ACTIVE, 640, visible columns (col < H_ACTIVE is visible)
- V_ACTIVE, 480, visible rows (row < V_ACTIVE is visible)

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- enable  in  1  block enable, same signal that drives the timing chain
- pixel_clk  in  1  one-clk pixel strobe, every 2nd clk
- counter_out_col  in  10  current column 0..799
- counter_out_row  in  10  current row 0..524
- counter_out_addr  in  ADDR_W  linear address of current pixel
- vblank_only  in  1  1 = grant writes only while row >= V_ACTIVE
- wr_req  in  1  writer request; level, held until wr_ack
- wr_addr  in  ADDR_W  write address, stable while wr_req=1
- wr_data  in  DATA_W  write data, stable while wr_req=1
- wr_ack  out  1  one-cycle grant pulse
- mem_addr  out  ADDR_W  SRAM address (registered)
- mem_wdata  out  DATA_W  SRAM write data (registered)
- mem_we  out  1  SRAM write strobe (registered)
- mem_re  out  1  SRAM read strobe (registered)
- mem_rdata  in  DATA_W  SRAM read data, valid the cycle after mem_re
- pix_data  out  DATA_W  pixel to DAC, 0 when blanked
- pix_valid  out  1  pix_data holds fetched memory data
- frame_start  out  1  one-cycle pulse at first pixel strobe of each frame in SCAN

Behaviour:
- Clock and reset: one clock `clk`; reset `n_rst` is asynchronous, active-low.
- Reset values:
  - All outputs are 0.
  - The FSM is in OFF.
  - Internal pipeline flags are 0.
- FSM states:
  - OFF: no memory operations; pix_data=0.
    - enable=1 -> SYNC.
  - SYNC: wait for alignment.
    - pixel_clk=1 with col=0 and row=0 -> SCAN; frame_start pulses next cycle.
    - No display reads in SYNC. Writes are allowed under the same rules as SCAN.
  - SCAN: normal operation.
    - frame_start pulses on every pixel_clk with col=0 and row=0.
  - Any state: enable=0 -> OFF next cycle. Any write granted that cycle still completes.
- Active region: active = (col < H_ACTIVE) && (row < V_ACTIVE). vblank = (row >= V_ACTIVE).
- Slot decision in cycle t (SCAN), registered into cycle t+1:
  - Read (priority): if pixel_clk && active, then mem_re=1 and mem_addr=counter_out_addr.
  - Write: otherwise, if wr_req && !wr_ack && (!vblank_only || vblank), then mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1.
  - Else: mem_re=mem_we=0. mem_addr and mem_wdata hold their last value.
- mem_re and mem_we are never both 1.
- Write bandwidth: during the active area the writer gets every non-strobe cycle, so it is never starved.
- Writer handshake:
  - The writer drops or updates wr_req on the clk edge where it samples wr_ack=1.
  - The `!wr_ack` term blocks a duplicate grant in the ack cycle.
- Display pipeline: strobe cycle t -> mem_re at t+1 -> mem_rdata at t+2 -> pix_data/pix_valid registered at t+3.
  - A strobe whose pixel is not active propagates along the same pipeline and sets pix_data=0, pix_valid=0 at t+3.
  - pix_data holds between updates.
- Reset asserted mid-transaction clears everything at once. The in-flight write is lost, and wr_ack does not pulse for it.

Decomposition:
- Shared package fb_pkg holds:
  - H_ACTIVE, V_ACTIVE, H_TOTAL=800, V_TOTAL=525;
  - the FSM state enum {OFF, SYNC, SCAN};
  - the slot-type enum {SLOT_NONE, SLOT_RD, SLOT_WR}.
- One sub-module, fb_pix_pipe: the 3-stage strobe/active/valid shift plus pix_data capture, keeping arbitration separate from display alignment.

Test Plan:
- Reset/idle: n_rst=0 then 1 with enable=0, toggling wr_req -> all outputs stay 0 and wr_ack never pulses.
- Frame sync: enable=1 with counters starting at col=5,row=3 -> no mem_re until col=0,row=0 strobe; frame_start pulses once per 800*525 strobes.
- Display read: strobe at col=10,row=2, addr=0x00A0A, mem_rdata=0x5C one cycle after mem_re -> mem_re=1 with mem_addr=0x00A0A at t+1; pix_data=0x5C, pix_valid=1 at t+3.
- Contention: wr_req held, addr=0x12345, data=0xA7, during active area -> writes only in non-strobe cycles; exactly one wr_ack; mem_we with 0x12345/0xA7 in the ack cycle; mem_re and mem_we never overlap.
- Tear-free: vblank_only=1, wr_req raised at row=100 -> wr_ack withheld until the row-480 region, then granted on the first eligible cycle.
- Blanking and abort: strobe at col=700 -> pix_data=0, pix_valid=0 at t+3. Asserting n_rst in a write grant cycle -> mem_we and wr_ack drop to 0 immediately.
